// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, flush
// handling and saturating bubble/flush event counters.
module id_ex_stage #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm_data,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic [4:0]      id_rd,
  input  logic [3:0]      id_funct4,
  input  logic [7:0]      id_ctrl,
  input  logic            flush,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rs1_data,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [XLEN-1:0] ex_imm_data,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic [4:0]      ex_rd,
  output logic [3:0]      ex_funct4,
  output logic [7:0]      ex_ctrl,
  output logic            hazard_stall,
  output logic [15:0]     bubble_count,
  output logic [15:0]     flush_count
);

  localparam int MEM_READ = 6;

  typedef enum logic [1:0] {
    ACT_LOAD,
    ACT_BUBBLE,
    ACT_FLUSH
  } act_e;

  act_e act;
  logic rd_hit;

  // No flush term here: upstream stall logic must not loop through flush.
  assign rd_hit = (ex_rd == id_rs1) | (ex_rd == id_rs2);
  assign hazard_stall = ex_valid & ex_ctrl[MEM_READ] & id_valid &
                        (ex_rd != 5'd0) & rd_hit;

  always_comb begin
    act = ACT_LOAD;
    if (flush)
      act = ACT_FLUSH;
    else if (hazard_stall)
      act = ACT_BUBBLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_valid     <= 1'b0;
      ex_pc        <= '0;
      ex_rs1_data  <= '0;
      ex_rs2_data  <= '0;
      ex_imm_data  <= '0;
      ex_rs1       <= '0;
      ex_rs2       <= '0;
      ex_rd        <= '0;
      ex_funct4    <= '0;
      ex_ctrl      <= '0;
      bubble_count <= '0;
      flush_count  <= '0;
    end else begin
      unique case (act)
        ACT_FLUSH: begin
          ex_valid    <= 1'b0;
          ex_ctrl     <= '0;
          ex_rd       <= '0;
          ex_pc       <= id_pc;
          ex_rs1_data <= id_rs1_data;
          ex_rs2_data <= id_rs2_data;
          ex_imm_data <= id_imm_data;
          ex_rs1      <= id_rs1;
          ex_rs2      <= id_rs2;
          ex_funct4   <= id_funct4;
          if (flush_count != 16'hFFFF)
            flush_count <= flush_count + 16'd1;
        end
        ACT_BUBBLE: begin
          ex_valid <= 1'b0;
          ex_ctrl  <= '0;
          ex_rd    <= '0;
          if (bubble_count != 16'hFFFF)
            bubble_count <= bubble_count + 16'd1;
        end
        default: begin
          ex_valid    <= id_valid;
          ex_ctrl     <= id_valid ? id_ctrl : 8'd0;
          ex_rd       <= id_valid ? id_rd : 5'd0;
          ex_pc       <= id_pc;
          ex_rs1_data <= id_rs1_data;
          ex_rs2_data <= id_rs2_data;
          ex_imm_data <= id_imm_data;
          ex_rs1      <= id_rs1;
          ex_rs2      <= id_rs2;
          ex_funct4   <= id_funct4;
        end
      endcase
    end
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter XLEN, default 64, datapath width of PC, register operands and immediate.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 id_valid  input  1  decode stage holds a real instruction.
REQ-005 id_pc  input  XLEN  PC of the decoded instruction.
REQ-006 id_rs1_data, id_rs2_data  input  XLEN each  register-file read data.
REQ-007 id_imm_data  input  XLEN  sign-extended immediate from the immediate extractor.
REQ-008 id_rs1, id_rs2, id_rd  input  5 each  register indices.
REQ-009 id_funct4  input  4  {instr[30], funct3}.
REQ-010 id_ctrl  input  8  {reg_write, mem_read, mem_write, mem_to_reg, branch, alu_src, alu_op[1:0]}.
REQ-011 flush  input  1  branch taken in a later stage; kill the instruction entering EX.
REQ-012 ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm_data, ex_rs1, ex_rs2, ex_rd, ex_funct4, ex_ctrl  output  widths as inputs  registered EX-stage copies.
REQ-013 hazard_stall  output  1  combinational; freeze PC and IF/ID register this cycle.
REQ-014 bubble_count  output  16  saturating count of inserted bubbles.
REQ-015 flush_count  output  16  saturating count of flushed slots.

Function
REQ-016 Load-use hazard: hazard_stall SHALL be 1 iff ex_valid & ex_ctrl.mem_read & id_valid & ex_rd != 0 & (ex_rd == id_rs1 | ex_rd == id_rs2); otherwise 0.
REQ-017 Each rising edge the stage SHALL take exactly one action, in priority order: flush, bubble, load.
REQ-018 Flush (flush = 1): ex_valid <= 0, ex_ctrl <= 0, ex_rd <= 0; other data fields don't-care but SHALL be loaded from ID; flush_count increments.
REQ-019 Bubble (flush = 0, hazard_stall = 1): ex_valid <= 0, ex_ctrl <= 0, ex_rd <= 0; bubble_count increments; the ID instruction is not consumed (upstream holds it).
REQ-020 Load (neither): all ex_* fields <= corresponding id_* fields one cycle later; if id_valid = 0 then ex_ctrl <= 0 and ex_rd <= 0.
REQ-021 ex_ctrl SHALL never carry nonzero bits while ex_valid = 0.
REQ-022 Latency: a non-stalled, non-flushed instruction appears on ex_* exactly 1 cycle after presentation.
REQ-023 A stalled instruction SHALL enter EX on the first cycle hazard_stall deasserts; at most one bubble per load-use pair (the bubble makes ex_valid = 0, clearing the hazard).
REQ-024 Flush and hazard in the same cycle: flush wins; only flush_count increments.
REQ-025 Counters SHALL saturate at 16'hFFFF, not wrap.
REQ-026 hazard_stall SHALL depend only on current ex_* registers and id_* inputs (no flush term), so upstream stall logic has no loop through flush.

Reset
REQ-027 reset_n = 0 SHALL immediately clear all ex_* outputs, bubble_count and flush_count to 0, independent of clk.
REQ-028 hazard_stall SHALL read 0 during reset (ex_valid = 0).
REQ-029 Reset asserted mid-stall SHALL discard the pending bubble; first post-reset edge performs a normal load.

Verification
REQ-030 Load x5 (mem_read=1, rd=5) then add rs1=5: cycle 2 hazard_stall=1, ex_valid=0, ex_ctrl=0, bubble_count=1; cycle 3 add on ex_*, hazard_stall=0.
REQ-031 Load with rd=0 followed by consumer of x0 -> hazard_stall=0, no bubble, counts unchanged.
REQ-032 flush=1 concurrent with load-use condition -> ex_valid=0, flush_count=1, bubble_count=0.
REQ-033 Stream of 3 independent ALU ops, imm_data=64'hFFFF_FFFF_FFFF_FFF8 -> each on ex_* one cycle later, ex_imm_data bit-exact, hazard_stall=0 throughout.
REQ-034 Force 65540 back-to-back flushes -> flush_count holds 16'hFFFF.
REQ-035 Assert reset_n=0 between clock edges while ex_valid=1 -> ex_valid, ex_ctrl, counters read 0 before next edge.
